// File: rtl/add_result_checker.sv
// Scoreboard for the operand adder: queues expected sums, compares them with reported results,
// and keeps pass/fail counts and first-mismatch capture. Optional X/Z detection: ADD_CHECK_XZ_EN.
//
// state  | meaning
// S_IDLE | after reset, waiting for start; inputs ignored
// S_RUN  | capturing operands and comparing results
// S_DONE | target compares reached; inputs ignored until start
module add_result_checker #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] target,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             res_valid,
    input  logic [WIDTH:0]   res_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             fail_seen,
    output logic [WIDTH:0]   fail_exp,
    output logic [WIDTH:0]   fail_got,
    output logic             ovf,
    output logic             unexp,
    output logic             xz_seen
);

    localparam int RW = WIDTH + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      Q_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]      Q_ONE   = 1;
    localparam logic [AW-1:0]    PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [RW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      q_cnt;
    logic [CNT_W-1:0] tgt_r, cmp_cnt, cmp_nxt;
    logic [RW-1:0]    sum, cmp_exp;
    logic             run, q_empty, q_full;
    logic             bypass, push, pop, cmp, drop, no_exp, miss, xz;

    always_comb begin
        run     = (state == S_RUN) && !start;
        q_empty = (q_cnt == '0);
        q_full  = (q_cnt == Q_FULL);
        sum     = RW'(in_a) + RW'(in_b);
        // Empty queue with operands and result together: the adder is combinational, compare directly.
        bypass  = run && q_empty && in_valid && res_valid;
        pop     = run && res_valid && !q_empty;
        push    = run && in_valid && !bypass && (!q_full || res_valid);
        drop    = run && in_valid && q_full && !res_valid;
        no_exp  = run && res_valid && q_empty && !in_valid;
        cmp     = bypass || pop;
        cmp_exp = bypass ? sum : mem[rd_ptr];
        cmp_nxt = cmp_cnt + CNT_ONE;
`ifdef ADD_CHECK_XZ_EN
        xz      = ((^res_o) === 1'bx);
        miss    = (res_o !== cmp_exp);
`else
        xz      = 1'b0;
        miss    = (res_o != cmp_exp);
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (start)
                    state_nxt = S_RUN;
                else if (cmp && (tgt_r != '0) && (cmp_nxt == tgt_r))
                    state_nxt = S_DONE;
            end
            S_DONE:  if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_RUN);
            done  <= (state_nxt == S_DONE);
        end
    end

    // Queue storage needs no reset; occupancy is tracked by q_cnt.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            q_cnt     <= '0;
            tgt_r     <= '0;
            cmp_cnt   <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            fail_seen <= 1'b0;
            fail_exp  <= '0;
            fail_got  <= '0;
            ovf       <= 1'b0;
            unexp     <= 1'b0;
            xz_seen   <= 1'b0;
        end else if (start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            q_cnt     <= '0;
            tgt_r     <= target;
            cmp_cnt   <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            fail_seen <= 1'b0;
            fail_exp  <= '0;
            fail_got  <= '0;
            ovf       <= 1'b0;
            unexp     <= 1'b0;
            xz_seen   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                q_cnt <= q_cnt + Q_ONE;
            else if (pop && !push)
                q_cnt <= q_cnt - Q_ONE;
            if (drop)
                ovf <= 1'b1;
            if (no_exp)
                unexp <= 1'b1;
            if (cmp) begin
                cmp_cnt <= cmp_nxt;
                if (xz)
                    xz_seen <= 1'b1;
                if (miss) begin
                    if (!(&fail_cnt))
                        fail_cnt <= fail_cnt + CNT_ONE;
                    if (!fail_seen) begin
                        fail_seen <= 1'b1;
                        fail_exp  <= cmp_exp;
                        fail_got  <= res_o;
                    end
                end else if (!(&pass_cnt)) begin
                    pass_cnt <= pass_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_add_result_checker.sv
// Directed and randomized bench for add_result_checker; expected outputs come from a
// queue-based behavioural model of the scoreboard rules.
module tb_add_result_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] target = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        res_valid = 1'b0;
    logic [8:0]  res_o = '0;
    logic        busy, done, fail_seen, ovf, unexp, xz_seen;
    logic [15:0] pass_cnt, fail_cnt;
    logic [8:0]  fail_exp, fail_got;

    int checks = 0;
    int errors = 0;

    // model: 0 idle, 1 run, 2 done
    int mq[$];
    int m_state, m_tgt, m_ncmp, m_pass, m_fail, m_fexp, m_fgot;
    bit m_fs, m_ovf, m_unexp;

    add_result_checker #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .target(target),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid), .res_o(res_o),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .fail_seen(fail_seen), .fail_exp(fail_exp), .fail_got(fail_got),
        .ovf(ovf), .unexp(unexp), .xz_seen(xz_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void m_clear();
        mq.delete();
        m_ncmp = 0; m_pass = 0; m_fail = 0; m_fexp = 0; m_fgot = 0;
        m_fs = 0; m_ovf = 0; m_unexp = 0;
    endfunction

    function automatic void m_cmp(int e, int g);
        m_ncmp = (m_ncmp + 1) & 16'hFFFF;
        if (e == g) begin
            if (m_pass < 65535) m_pass++;
        end else begin
            if (m_fail < 65535) m_fail++;
            if (!m_fs) begin m_fs = 1; m_fexp = e; m_fgot = g; end
        end
        if (m_tgt != 0 && m_ncmp == m_tgt) m_state = 2;
    endfunction

    function automatic void m_step(bit st, bit iv, bit rv);
        int s;
        s = int'(in_a) + int'(in_b);
        if (st) begin
            m_clear();
            m_state = 1;
            m_tgt = int'(target);
        end else if (m_state == 1) begin
            if (iv && rv && mq.size() == 0) begin
                m_cmp(s, int'(res_o));
            end else begin
                if (rv) begin
                    if (mq.size() == 0) m_unexp = 1;
                    else m_cmp(mq.pop_front(), int'(res_o));
                end
                if (iv) begin
                    if (mq.size() >= 4) m_ovf = 1;
                    else mq.push_back(s);
                end
            end
        end
    endfunction

    task automatic check_all(string ph);
        chk({ph, ".busy"}, busy, m_state == 1);
        chk({ph, ".done"}, done, m_state == 2);
        chk({ph, ".pass_cnt"}, pass_cnt, m_pass);
        chk({ph, ".fail_cnt"}, fail_cnt, m_fail);
        chk({ph, ".fail_seen"}, fail_seen, m_fs);
        chk({ph, ".fail_exp"}, fail_exp, m_fexp);
        chk({ph, ".fail_got"}, fail_got, m_fgot);
        chk({ph, ".ovf"}, ovf, m_ovf);
        chk({ph, ".unexp"}, unexp, m_unexp);
        chk({ph, ".xz_seen"}, xz_seen, 0);
    endtask

    // Drive one cycle (operands/target set by caller), update the model at the edge, check after it.
    task automatic step(string ph, bit st, bit iv, bit rv, logic [8:0] r);
        start = st; in_valid = iv; res_valid = rv; res_o = r;
        @(posedge clk);
        m_step(st, iv, rv);
        #1;
        start = 0; in_valid = 0; res_valid = 0;
        check_all(ph);
    endtask

    function automatic logic [8:0] good();
        if (mq.size() > 0) return 9'(mq[0]);
        return 9'(int'(in_a) + int'(in_b));
    endfunction

    initial begin
        m_state = 0; m_tgt = 0; m_clear();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // five zero-latency compares reaching target
        target = 16'd5; in_a = 0; in_b = 0;
        step("t1.start", 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            in_a = 8'(i); in_b = 0;
            step("t1.cmp", 0, 1, 1, 9'(i));
        end
        chk("t1.done_after_5", done, 1);
        chk("t1.pass5", pass_cnt, 5);
        in_a = 8'h11; in_b = 8'h22;
        step("t1.ignored", 0, 1, 1, 9'h000);

        // max operands, then first-mismatch capture and retention
        target = 0; in_a = 8'hFF; in_b = 8'hFF;
        step("t2.start", 1, 1, 1, 9'h1FE);
        step("t2.pass", 0, 1, 1, 9'h1FE);
        step("t2.fail1", 0, 1, 1, 9'h0FE);
        chk("t2.fail_exp", fail_exp, 9'h1FE);
        chk("t2.fail_got", fail_got, 9'h0FE);
        in_a = 8'h01; in_b = 8'h02;
        step("t2.fail2", 0, 1, 1, 9'h005);
        chk("t2.fail_exp_kept", fail_exp, 9'h1FE);
        chk("t2.fail_got_kept", fail_got, 9'h0FE);

        // overflow, drain, unexpected result
        step("t3.start", 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            in_a = 8'($urandom); in_b = 8'($urandom);
            step("t3.push", 0, 1, 0, 0);
        end
        chk("t3.ovf", ovf, 1);
        for (int i = 0; i < 4; i++) step("t3.drain", 0, 0, 1, good());
        chk("t3.pass4", pass_cnt, 4);
        step("t3.extra", 0, 0, 1, 9'h055);
        chk("t3.unexp", unexp, 1);

        // full queue with simultaneous push and pop
        step("t4.start", 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            in_a = 8'($urandom); in_b = 8'($urandom);
            step("t4.fill", 0, 1, 0, 0);
        end
        for (int i = 0; i < 10; i++) begin
            in_a = 8'($urandom); in_b = 8'($urandom);
            step("t4.pp", 0, 1, 1, good());
        end
        chk("t4.no_ovf", ovf, 0);
        chk("t4.pass10", pass_cnt, 10);

        // reset mid-run then restart
        target = 16'd5;
        step("t5.start", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            in_a = 8'($urandom); in_b = 8'($urandom);
            step("t5.cmp", 0, 1, 1, good());
        end
        rst_n = 1'b0;
        #1;
        m_state = 0; m_tgt = 0; m_clear();
        check_all("t5.reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("t5.idle");
        in_a = 8'h10; in_b = 8'h20;
        step("t5.idle_ignored", 0, 1, 1, 9'h030);
        target = 16'd3;
        step("t5.restart", 1, 1, 1, 9'h030);
        chk("t5.pass_zero", pass_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            in_a = 8'($urandom); in_b = 8'($urandom);
            step("t5.cmp2", 0, 1, 1, good());
        end
        chk("t5.done", done, 1);

        // randomized traffic with occasional wrong results
        for (int r = 0; r < 4; r++) begin
            target = 16'($urandom_range(0, 30));
            step("rnd.start", 1, 0, 0, 0);
            for (int i = 0; i < 80; i++) begin
                bit iv, rv;
                logic [8:0] rr;
                in_a = 8'($urandom); in_b = 8'($urandom);
                iv = 1'($urandom_range(0, 1));
                rv = 1'($urandom_range(0, 1));
                rr = ($urandom_range(0, 7) == 0) ? 9'($urandom) : good();
                step("rnd", 0, iv, rv, rr);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_result_checker.md
Name: add_result_checker

Overview:
Scoreboard stage directly downstream of the testbench operand adder (o = a + b, 9-bit result from 8-bit operands). Captures each operand pair driven into the adder, queues the expected sum, and compares it against the adder result when that result is reported. Keeps pass/fail counts, captures the first mismatch, and reports completion, so VPI-driven tests can poll one block instead of parsing $monitor output.

Parameters:
WIDTH, 8, operand width; result width is WIDTH+1
DEPTH, 4, expected-value queue depth (power of two, >=2)
CNT_W, 16, width of pass/fail/target counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; latches target, clears counters and flags, enters RUN
target  in  CNT_W  number of compares to perform before DONE (0 = run until next start)
in_valid  in  1  operand pair presented to adder this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
res_valid  in  1  adder result valid this cycle
res_o  in  WIDTH+1  adder result
busy  out  1  high in RUN
done  out  1  high in DONE
pass_cnt  out  CNT_W  matching compares, saturating
fail_cnt  out  CNT_W  mismatching compares, saturating
fail_seen  out  1  sticky; any mismatch since start
fail_exp  out  WIDTH+1  expected value of first mismatch
fail_got  out  WIDTH+1  received value of first mismatch
ovf  out  1  sticky; push attempted while queue full
unexp  out  1  sticky; result arrived with nothing expected
xz_seen  out  1  sticky; X/Z seen on res_o (see Optional Feature)

Behaviour:
- Reset (async, rst_n low): state IDLE; queue empty; every output 0.
- States: IDLE -> RUN on start; RUN -> DONE when compares made == target and target != 0; DONE -> RUN on start; start in RUN restarts (clear + relatch). No other transitions.
- In IDLE/DONE: in_valid and res_valid are ignored; queue is not written; counters hold.
- start clears the queue, counters, fail_*, ovf, unexp and xz_seen in the same edge. A start coinciding with in_valid/res_valid discards those events.
- Expected value = zero-extended in_a + in_b, WIDTH+1 bits, no truncation.
- Push: in_valid in RUN writes the expected value to the queue tail.
- Pop/compare: res_valid in RUN pops the queue head and compares it with res_o.
- Bypass: queue empty and in_valid and res_valid in the same cycle -> compare res_o directly against this cycle's in_a+in_b; nothing is queued. This supports the zero-latency combinational adder.
- Queue full with push and pop in the same cycle: both happen, no ovf.
- Queue full with push only: push dropped, ovf=1.
- Queue empty with res_valid and no in_valid: unexp=1; no count change; does not count toward target.
- Match: pass_cnt+1. Mismatch: fail_cnt+1. Both saturate at all-ones.
- First mismatch only: fail_seen=1 and fail_exp/fail_got load. Later mismatches do not overwrite them.
- Compare count = pass+fail, using a non-saturating internal counter. When the compare that reaches target is made, DONE is entered on the next edge; that compare is counted.
- All outputs registered; counters and flags update one cycle after the qualifying input edge.

Optional Feature:
ADD_CHECK_XZ_EN
- Defined:
  - a res_valid compare where res_o contains any X/Z bit counts as a mismatch;
  - sets xz_seen;
  - fail_got captures the raw value;
  - the compare uses case equality.
- Undefined: xz_seen tied 0; compare uses logical equality; behaviour on X inputs is unspecified (synthesizable build).

Test Plan:
- Reset, then start with target=5; drive a=0..4, b=0 with zero-latency results -> pass_cnt=5, fail_cnt=0, done=1 in the cycle after the 5th compare, busy=0.
- Operands a=8'hFF, b=8'hFF, res_o=9'h1FE -> pass; then res_o=9'h0FE -> fail_cnt=1, fail_exp=9'h1FE, fail_got=9'h0FE; a second mismatch leaves fail_exp/fail_got unchanged.
- DEPTH=4: push 5 pairs with no results -> ovf=1 after 5th push; then 4 correct results -> pass_cnt=4, queue empty; one extra res_valid -> unexp=1, counts unchanged.
- Queue full with simultaneous push and pop for 10 cycles -> no ovf, results matched in FIFO order, pass_cnt=10.
- Mid-run: deassert rst_n for 1 cycle after 3 of 5 compares -> all outputs 0, state IDLE; start again -> counters restart from 0.
- With ADD_CHECK_XZ_EN: res_o=9'bx for one compare -> xz_seen=1, fail_cnt=1; without the macro, xz_seen stays 0.
